// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coder bit packer.
package jpeg_pkg;

    // Packer control states: accept codes, pad to a byte boundary, then empty out.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } pack_state_e;

    // A byte equal to MARKER_FF in entropy-coded data must be followed by STUFF_BYTE
    // so that the decoder does not mistake it for a marker prefix.
    localparam logic [7:0] MARKER_FF  = 8'hFF;
    localparam logic [7:0] STUFF_BYTE = 8'h00;

    // Number of one-bits needed to bring a bit count up to the next byte boundary,
    // i.e. (8 - cnt mod 8) mod 8, which is the two's complement of the low three bits.
    function automatic logic [2:0] pad_bits(input logic [2:0] cnt_lsb);
        return 3'(~cnt_lsb + 3'd1);
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output stage of the bit packer: presents the oldest accumulator byte, inserts a
// 0x00 after every emitted 0xFF and moves the end-of-flush flag onto that 0x00.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
#(
    parameter int STUFF_EN = 1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_valid_i,
    input  logic [7:0] data_byte_i,
    input  logic       data_last_i,
    input  logic       out_ready_i,
    output logic       data_take_o,
    output logic       stuff_pend_o,
    output logic       out_valid_o,
    output logic [7:0] out_byte_o,
    output logic       out_last_o
);

    logic stuff_q, stuff_d;
    logic stuff_last_q, stuff_last_d;
    logic is_marker;

    // A data byte only leaves the accumulator when no stuff byte is ahead of it.
    assign is_marker    = (STUFF_EN != 0) && (data_byte_i == MARKER_FF);
    assign data_take_o  = data_valid_i && !stuff_q && out_ready_i;
    assign stuff_pend_o = stuff_q;

    // Output mux: a pending stuff byte takes priority over accumulator data.
    always_comb begin
        out_valid_o = stuff_q || data_valid_i;
        out_byte_o  = data_byte_i;
        out_last_o  = data_last_i && !is_marker;
        if (stuff_q) begin
            out_byte_o = STUFF_BYTE;
            out_last_o = stuff_last_q;
        end
    end

    // Stuff-pending bookkeeping: armed by an accepted 0xFF, cleared when the 0x00 leaves.
    always_comb begin
        stuff_d      = stuff_q;
        stuff_last_d = stuff_last_q;
        if (stuff_q) begin
            if (out_ready_i) begin
                stuff_d      = 1'b0;
                stuff_last_d = 1'b0;
            end
        end else if (data_take_o && is_marker) begin
            stuff_d      = 1'b1;
            stuff_last_d = data_last_i;
        end
    end

    // Stuff register; reset drops any stuff byte that has not gone out yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuff_q      <= 1'b0;
            stuff_last_q <= 1'b0;
        end else begin
            stuff_q      <= stuff_d;
            stuff_last_q <= stuff_last_d;
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into a byte stream. Codes are kept
// left-justified in an accumulator; the oldest byte is offered downstream directly
// from the accumulator register, so a byte is visible the cycle after its last bit
// was accepted. A flush pads with one-bits to a byte boundary and drains everything.
// ACC_W is expected to be a multiple of 8 so padding never overruns the accumulator.
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter  int CODE_W   = 16,
    parameter  int ACC_W    = 32,
    parameter  int STUFF_EN = 1,
    localparam int LEN_W    = $clog2(CODE_W + 1)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              flush_done
);

    localparam int               CNT_W     = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] RDY_MAX   = CNT_W'(ACC_W - CODE_W);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
    localparam logic [CNT_W-1:0] ACC_BITS  = CNT_W'(ACC_W);

    // Lengths beyond the code width are clamped to the code width.
    function automatic logic [CNT_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (int'(len) > CODE_W) begin
            return CNT_W'(CODE_W);
        end
        return CNT_W'(len);
    endfunction

    pack_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_done_q, flush_done_d;

    logic             accept;
    logic             data_valid;
    logic             data_last;
    logic             data_take;
    logic             stuff_pend;
    logic [7:0]       data_byte;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] pad_len;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W-1:0] code_top;
    logic [ACC_W-1:0] pad_top;
    logic [ACC_W-1:0] acc_base;

    // Ready depends on registered state only, never on out_ready.
    assign in_ready   = (state_q == ST_RUN) && (cnt_q <= RDY_MAX);
    assign accept     = in_valid && in_ready;
    assign data_valid = (cnt_q >= BYTE_BITS);
    assign data_byte  = acc_q[ACC_W-1 -: 8];
    // After a flush the accumulator holds whole bytes, so exactly 8 bits left marks the final one.
    assign data_last  = (state_q != ST_RUN) && (cnt_q == BYTE_BITS);
    assign flush_done = flush_done_q;

    jpeg_byte_stuffer #(
        .STUFF_EN (STUFF_EN)
    ) u_stuffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_valid_i (data_valid),
        .data_byte_i  (data_byte),
        .data_last_i  (data_last),
        .out_ready_i  (out_ready),
        .data_take_o  (data_take),
        .stuff_pend_o (stuff_pend),
        .out_valid_o  (out_valid),
        .out_byte_o   (out_byte),
        .out_last_o   (out_last)
    );

    // Align the masked code and the pad ones at the top, and remove the departing byte.
    always_comb begin
        len_eff  = sat_len(in_len);
        code_top = (ACC_W'(in_code) & ((ACC_W'(1) << len_eff) - ACC_W'(1)))
                   << (ACC_BITS - len_eff);
        pad_len  = CNT_W'(pad_bits(cnt_q[2:0]));
        pad_top  = ~({ACC_W{1'b1}} >> pad_len);
        acc_base = data_take ? (acc_q << 8) : acc_q;
        cnt_base = data_take ? (cnt_q - BYTE_BITS) : cnt_q;
    end

    // Flush sequencing: one pad cycle, then drain until nothing is left to send.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (accept && in_flush) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((cnt_q == '0) && !stuff_pend) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Append new bits just below the ones already held; emission and append share a cycle.
    always_comb begin
        acc_d = acc_base;
        cnt_d = cnt_base;
        if (accept) begin
            acc_d = acc_base | (code_top >> cnt_base);
            cnt_d = cnt_base + len_eff;
        end else if (state_q == ST_PAD) begin
            acc_d = acc_base | (pad_top >> cnt_base);
            cnt_d = cnt_base + pad_len;
        end
    end

    // State, accumulator and flush pulse registers; reset discards all buffered bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: doc/jpeg_bit_packer.md
JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

Interface
REQ-001 Parameter CODE_W, default 16, maximum code length in bits (1..24).
REQ-002 Parameter ACC_W, default 32, accumulator width in bits; SHALL satisfy ACC_W >= CODE_W+8.
REQ-003 Parameter STUFF_EN, default 1, enables JPEG 0xFF->0xFF00 byte stuffing.
REQ-004 Derived LEN_W = $clog2(CODE_W+1).
REQ-005 Clock and reset: one clock; reset is synchronous and active-low, ports clk, rst_n.
REQ-006 Ports, one per line:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  code word present.
- in_ready  out  1  packer accepts code this cycle.
- in_code  in  CODE_W  code, right-justified, sent MSB-first.
- in_len  in  LEN_W  valid bits in in_code (0..CODE_W).
- in_flush  in  1  with in_valid: pad and drain after this code.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  downstream accepts byte.
- out_byte  out  8  packed byte.
- out_last  out  1  final byte of a flush.
- flush_done  out  1  one-cycle pulse, flush complete.

Function
REQ-007 Transfer occurs on valid&&ready at a rising clk edge, on both ports.
REQ-008 Accepted code: low in_len bits appended MSB-first after existing accumulator bits; bits above in_len ignored; in_len > CODE_W saturated to CODE_W.
REQ-009 in_len = 0 SHALL be legal and append nothing.
REQ-010 in_ready = (state==RUN) && (cnt + CODE_W <= ACC_W), from registers only, no combinational path from out_ready.
REQ-011 out_valid SHALL assert when cnt >= 8 or a stuff byte is pending; out_byte = oldest 8 bits (or 0x00 when stuffing).
REQ-012 Latency: code accepted at edge t, first resulting byte valid after edge t (registered, 1 cycle).
REQ-013 While out_valid=1 and out_ready=0, out_byte and out_last SHALL hold stable.
REQ-014 Simultaneous accept and emit in one cycle: cnt_next = cnt + len - 8 (or cnt + len for a stuff byte); no bubble.
REQ-015 STUFF_EN=1: each emitted 0xFF SHALL be followed by 0x00 before any further byte; STUFF_EN=0: no insertion.
REQ-016 States: RUN, PAD, DRAIN. RUN->PAD on accepted code with in_flush=1; PAD->DRAIN after (8 - cnt mod 8) mod 8 one-bits appended (one cycle); DRAIN->RUN when cnt=0 and no stuff pending.
REQ-017 in_ready = 0 in PAD and DRAIN.
REQ-018 out_last SHALL mark the final byte of a drain; if that byte is 0xFF with stuffing, out_last moves to the trailing 0x00.
REQ-019 flush_done pulses one cycle on the DRAIN->RUN transition; flush with cnt=0 after append emits no bytes and pulses flush_done two cycles after accept.

Reset
REQ-020 rst_n=0 at an edge: cnt=0, accumulator=0, state=RUN, stuff-pending=0, out_valid=0, out_last=0, flush_done=0; in_ready=1 the cycle after release.
REQ-021 Reset mid-operation SHALL discard all buffered bits and pending stuff bytes without emitting them.

Structure
REQ-022 Shared package jpeg_pkg SHALL hold the state enum, MARKER_FF = 8'hFF, STUFF_BYTE = 8'h00.
REQ-023 One sub-module jpeg_byte_stuffer (1-byte output register with 0x00 insertion and out_last relocation) SHALL be instantiated; the accumulator/FSM stays in jpeg_bit_packer.

Verification
REQ-024 code 3'b101 len 3, in_flush=1, out_ready=1 -> single byte 0xBF with out_last=1, then flush_done pulse.
REQ-025 0xFF len 8, 0x12 len 8, then len 0 flush -> bytes FF, 00, 12; out_last on 12 only.
REQ-026 code 3'b111 len 3 with flush -> pad yields FF, then 00 carrying out_last=1.
REQ-027 twenty 16-bit codes 0xA5C3 with out_ready low for 10 cycles -> in_ready drops at cnt > 16, no loss, output A5 C3 repeated 20 times, bytes stable while stalled.
REQ-028 rst_n low for one cycle with 13 bits buffered -> out_valid=0 next cycle, no residual bytes; next code 0xAB len 8 -> single byte AB.
REQ-029 len 0 flush at cnt=0 -> no out_valid, flush_done pulses once.
